// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter
// Arbitrates two requesters for a shared SR latch. The granted requester's
// operation (1 = set, 0 = clear) is applied as a PULSE_CYC-cycle pulse on s or r.
// After SETTLE_CYC idle cycles the latch outputs are checked. A failed check
// re-drives the pulse up to MAX_RETRY times. Completion is reported with a
// one-cycle ack (plus err if every attempt failed).
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   req[1:0]   per-requester request level, held until ack
//   op[1:0]    per-requester operation, 1 = set, 0 = clear
//   ack[1:0]   one-cycle completion pulse to the owner
//   err[1:0]   one-cycle error flag, only together with ack
//   s, r       set / reset drives to the shared latch
//   q, q_bar   latch outputs fed back for the check
//   busy       high whenever the FSM is not idle
//   owner      index of the currently granted requester
module sr_flag_arbiter #(
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 1,
  parameter int MAX_RETRY  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] op,
  output logic [1:0] ack,
  output logic [1:0] err,
  output logic       s,
  output logic       r,
  input  logic       q,
  input  logic       q_bar,
  output logic       busy,
  output logic       owner
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    ACK    = 3'd4
  } state_t;

  state_t     state_r;
  logic [3:0] cnt_r;      // cycles remaining in DRIVE / SETTLE, minus one
  logic [2:0] retry_r;    // re-drives already spent on this transaction
  logic       op_r;       // operation latched at grant
  logic       last_r;     // requester granted most recently
  logic       grant_s;
  logic       pass_s;

  // Map a requester index to its one-hot ack/err lane.
  function automatic logic [1:0] lane(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // Round-robin choice: on a tie the requester not granted last wins.
  always_comb begin
    grant_s = 1'b0;
    if (req == 2'b11) begin
      grant_s = ~last_r;
    end else if (req[1]) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Latch verification: both rails must agree with the requested value.
  always_comb begin
    pass_s = 1'b0;
    if ((q == op_r) && (q_bar == ~op_r)) begin
      pass_s = 1'b1;
    end else begin
      pass_s = 1'b0;
    end
  end

  // Transaction FSM; every output is registered on entry to its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      retry_r <= 3'd0;
      op_r    <= 1'b0;
      last_r  <= 1'b1;   // requester 0 wins the first tie
      owner   <= 1'b0;
      s       <= 1'b0;
      r       <= 1'b0;
      ack     <= 2'b00;
      err     <= 2'b00;
      busy    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ack <= 2'b00;
          err <= 2'b00;
          if (req != 2'b00) begin
            owner   <= grant_s;
            op_r    <= op[grant_s];
            retry_r <= 3'd0;
            cnt_r   <= 4'(PULSE_CYC - 1);
            s       <= op[grant_s];
            r       <= ~op[grant_s];
            busy    <= 1'b1;
            state_r <= DRIVE;
          end else begin
            s    <= 1'b0;
            r    <= 1'b0;
            busy <= 1'b0;
          end
        end
        DRIVE: begin
          if (cnt_r == 4'd0) begin
            s       <= 1'b0;
            r       <= 1'b0;
            cnt_r   <= 4'(SETTLE_CYC - 1);
            state_r <= SETTLE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        SETTLE: begin
          if (cnt_r == 4'd0) begin
            state_r <= CHECK;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        CHECK: begin
          if (pass_s) begin
            ack     <= lane(owner);
            err     <= 2'b00;
            state_r <= ACK;
          end else if (retry_r < 3'(MAX_RETRY)) begin
            retry_r <= retry_r + 3'd1;
            cnt_r   <= 4'(PULSE_CYC - 1);
            s       <= op_r;
            r       <= ~op_r;
            state_r <= DRIVE;
          end else begin
            ack     <= lane(owner);
            err     <= lane(owner);
            state_r <= ACK;
          end
        end
        ACK: begin
          ack     <= 2'b00;
          err     <= 2'b00;
          last_r  <= owner;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          s       <= 1'b0;
          r       <= 1'b0;
          ack     <= 2'b00;
          err     <= 2'b00;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb_sr_flag_arbiter
// Directed plus randomized transactions against sr_flag_arbiter with default
// parameters. A behavioural SR latch sits on s/r. Its q can be held wrong for
// the first K pulses of a transaction. Expected timing, pulse counts, ack/err
// lanes and tie winners come from the protocol rules:
//   ack edge = grant edge + (PULSE+SETTLE+1) * (retries + 1)
//   retries  = min(K, MAX)
//   err      = (K > MAX)
module tb_sr_flag_arbiter;

  localparam int P = 2;
  localparam int S = 1;
  localparam int M = 3;
  localparam int L = P + S + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [1:0] op;
  logic [1:0] ack;
  logic [1:0] err;
  logic       s;
  logic       r;
  logic       q;
  logic       q_bar;
  logic       busy;
  logic       owner;

  int checks = 0;
  int errors = 0;

  int   cyc = 0;
  int   s_cnt = 0;
  int   r_cnt = 0;
  int   episodes = 0;
  int   viol = 0;
  logic drv_prev = 1'b0;
  logic busy_prev = 1'b0;

  logic lat = 1'b0;
  int   stuck_k = 0;
  int   ep_base = 0;
  logic tgt = 1'b0;
  int   ref_last = 1;

  sr_flag_arbiter #(.PULSE_CYC(P), .SETTLE_CYC(S), .MAX_RETRY(M)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .ack(ack), .err(err),
    .s(s), .r(r), .q(q), .q_bar(q_bar), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Latch model: responds to the drives present during each cycle.
  always @(posedge clk) begin
    if (s) lat <= 1'b1;
    else if (r) lat <= 1'b0;
  end

  // Faulty latch: q reads wrong while this transaction has seen <= K pulses.
  assign q     = ((stuck_k > 0) && ((episodes - ep_base) <= stuck_k)) ? ~tgt : lat;
  assign q_bar = ~q;

  // Monitor: pulse bookkeeping and protocol invariants.
  always @(negedge clk) begin
    s_cnt     <= s_cnt + (s ? 1 : 0);
    r_cnt     <= r_cnt + (r ? 1 : 0);
    episodes  <= episodes + (((s | r) && !drv_prev) ? 1 : 0);
    drv_prev  <= s | r;
    busy_prev <= busy;
    if (!reset && ((s && r) || ((ack != 2'b00) && !busy_prev) ||
                   ((err & ~ack) != 2'b00) || (ack == 2'b11)))
      viol <= viol + 1;
  end

  function automatic logic [1:0] oh(input int w);
    return (w != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output int e_edge, output logic [1:0] a, output logic [1:0] er);
    e_edge = -1;
    a = 2'b00;
    er = 2'b00;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        e_edge = cyc;
        a = ack;
        er = err;
        break;
      end
    end
    chk("ack_seen", (e_edge >= 0) ? 1 : 0, 1);
  endtask

  task automatic do_single(input int who, input logic o, input int k, input bit drop);
    int ret, g_edge, a_edge, s0, r0;
    logic [1:0] a, e;
    bit is_err;
    ret = (k > M) ? M : k;
    is_err = (k > M);
    @(negedge clk);
    stuck_k = k;
    tgt = o;
    ep_base = episodes;
    s0 = s_cnt;
    r0 = r_cnt;
    op[who] = o;
    req[who] = 1'b1;
    g_edge = cyc + 1;
    @(negedge clk);
    op[who] = ~o;                 // must be ignored after grant
    if (drop) req[who] = 1'b0;    // must not abort
    wait_ack(a_edge, a, e);
    chk("single_lat", a_edge, g_edge + L * (ret + 1));
    chk("single_ack", a, oh(who));
    chk("single_err", e, is_err ? oh(who) : 2'b00);
    chk("single_s", s_cnt - s0, o ? P * (ret + 1) : 0);
    chk("single_r", r_cnt - r0, o ? 0 : P * (ret + 1));
    req[who] = 1'b0;
    stuck_k = 0;
    ref_last = who;
    if (!is_err) chk("single_latch", lat, o);
    @(negedge clk);
    chk("single_idle_busy", busy, 1'b0);
    chk("single_idle_ack", ack, 2'b00);
  endtask

  task automatic do_dual(input logic o0, input logic o1);
    int win, lose, g_edge, a_edge, s0, r0;
    logic [1:0] a, e;
    logic ow, ol;
    win = 1 - ref_last;
    lose = ref_last;
    ow = (win == 0) ? o0 : o1;
    ol = (win == 0) ? o1 : o0;
    @(negedge clk);
    s0 = s_cnt;
    r0 = r_cnt;
    op = {o1, o0};
    req = 2'b11;
    g_edge = cyc + 1;
    wait_ack(a_edge, a, e);
    chk("dual1_lat", a_edge, g_edge + L);
    chk("dual1_ack", a, oh(win));
    chk("dual1_err", e, 2'b00);
    chk("dual1_s", s_cnt - s0, ow ? P : 0);
    chk("dual1_r", r_cnt - r0, ow ? 0 : P);
    req[win] = 1'b0;
    ref_last = win;
    g_edge = a_edge + 2;          // loser granted from the idle cycle after ack
    s0 = s_cnt;
    r0 = r_cnt;
    wait_ack(a_edge, a, e);
    chk("dual2_lat", a_edge, g_edge + L);
    chk("dual2_ack", a, oh(lose));
    chk("dual2_err", e, 2'b00);
    chk("dual2_s", s_cnt - s0, ol ? P : 0);
    chk("dual2_r", r_cnt - r0, ol ? 0 : P);
    chk("dual2_latch", lat, ol);
    req[lose] = 1'b0;
    ref_last = lose;
    @(negedge clk);
    chk("dual_idle_busy", busy, 1'b0);
  endtask

  initial begin
    int acc;
    reset = 1'b1;
    req = 2'b00;
    op = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_s", s, 1'b0);
    chk("rst_r", r, 1'b0);
    chk("rst_ack", ack, 2'b00);
    chk("rst_err", err, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 1'b0);
    reset = 1'b0;
    ref_last = 1;

    // Tie from reset: requester 0 clears first, then requester 1 sets.
    do_dual(1'b0, 1'b1);
    // Next tie goes back to requester 0.
    do_dual(1'b1, 1'b0);
    // Single set, no fault.
    do_single(0, 1'b1, 0, 1'b0);
    // Stuck latch: all four attempts fail.
    do_single(1, 1'b1, 4, 1'b0);
    // Recovery on the first retry.
    do_single(0, 1'b1, 1, 1'b0);
    // Clear with request dropped mid-transaction.
    do_single(1, 1'b0, 0, 1'b1);

    // Reset during the second DRIVE cycle aborts without ack.
    @(negedge clk);
    op[0] = 1'b1;
    req[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_s", s, 1'b0);
    chk("abort_r", r, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ack", ack, 2'b00);
    chk("abort_owner", owner, 1'b0);
    reset = 1'b0;
    req[0] = 1'b0;
    ref_last = 1;
    acc = 0;
    repeat (8) begin
      @(negedge clk);
      acc = acc + ((ack != 2'b00) ? 1 : 0);
    end
    chk("abort_no_ack", acc, 0);
    do_dual(1'b1, 1'b1);

    // Randomized mix of single (with faults) and contending transactions.
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) == 0)
        do_dual(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        do_single($urandom_range(0, 1), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end

    chk("invariants", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_flag_arbiter.md
SR_FLAG_ARBITER -- requirements
Module: sr_flag_arbiter

Interface
REQ-001 Parameter PULSE_CYC, default 2, number of cycles a set/reset pulse is driven to the latch (legal 1..15).
REQ-002 Parameter SETTLE_CYC, default 1, number of idle cycles between pulse end and the q check (legal 1..15).
REQ-003 Parameter MAX_RETRY, default 3, number of re-drives allowed after a failed check (legal 0..7).
REQ-004 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port req  input  2  per-requester transaction request; level, held until ack.
REQ-007 Port op  input  2  per-requester operation: 1 = set flag, 0 = clear flag; stable while req high.
REQ-008 Port ack  output  2  one-cycle completion pulse to the owning requester.
REQ-009 Port err  output  2  one-cycle error flag, valid only together with ack.
REQ-010 Port s  output  1  set drive to the shared SR latch.
REQ-011 Port r  output  1  reset drive to the shared SR latch.
REQ-012 Port q  input  1  latch q, fed back for verification.
REQ-013 Port q_bar  input  1  latch q_bar, fed back for verification.
REQ-014 Port busy  output  1  high whenever state is not IDLE.
REQ-015 Port owner  output  1  index of the requester currently granted; meaningful only while busy.

Function
REQ-016 The block SHALL be an FSM with states IDLE, DRIVE, SETTLE, CHECK, ACK.
REQ-017 In IDLE with any req bit high, the block SHALL grant one requester, latch its op, clear the retry count and enter DRIVE on the next edge.
REQ-018 Arbitration SHALL be round-robin: with both req high, the requester not granted last wins; with one req high, that requester wins.
REQ-019 In DRIVE the block SHALL assert s (latched op = 1) or r (latched op = 0) for exactly PULSE_CYC cycles, then enter SETTLE.
REQ-020 s and r SHALL never be high in the same cycle, and both SHALL be low in every state except DRIVE.
REQ-021 In SETTLE both drives SHALL be low for exactly SETTLE_CYC cycles, then the block SHALL enter CHECK.
REQ-022 CHECK (one cycle) SHALL pass when q == latched op and q_bar == ~latched op.
REQ-023 On pass the block SHALL enter ACK; on fail with retry count < MAX_RETRY it SHALL increment the count and re-enter DRIVE; on fail with retry count == MAX_RETRY it SHALL enter ACK with error pending.
REQ-024 In ACK the block SHALL pulse ack[owner] for one cycle, drive err[owner] = 1 only if error pending, update the last-granted pointer to owner, and return to IDLE.
REQ-025 Latency without retries: req first sampled high at edge N SHALL yield ack high in cycle N + PULSE_CYC + SETTLE_CYC + 2 (cycle 5 with defaults); each retry SHALL add PULSE_CYC + SETTLE_CYC + 1 cycles.
REQ-026 Only one transaction SHALL be in flight; requests arriving while busy SHALL wait, and the losing request SHALL be granted from the IDLE cycle following ACK.
REQ-027 A req deasserted mid-transaction SHALL NOT abort it; the transaction completes and ack still pulses.
REQ-028 op changes after grant SHALL be ignored.
REQ-029 ack and err bits for the non-owning requester SHALL remain 0 at all times.

Reset
REQ-030 While reset is high at a rising edge the block SHALL enter IDLE, and s, r, ack, err, busy, owner, retry count SHALL be 0, with the last-granted pointer set so requester 0 wins the first tie.
REQ-031 Reset asserted mid-transaction SHALL take effect at the next edge with no ack or err emitted for the aborted transaction.

Verification
REQ-032 Single set: req=01, op=01, latch model follows s/r -> s high cycles 1-2, ack=01 in cycle 5, err=00, q=1.
REQ-033 Contention: req=11 from reset, op=10 -> requester 0 clears first (r pulsed, ack=01), requester 1 then sets (s pulsed, ack=10); next tie goes to requester 0.
REQ-034 Stuck latch: q forced 0, q_bar forced 1, set request, MAX_RETRY=3 -> four s pulses, then ack with err for that requester, ack in cycle 5 + 3*4 = 17.
REQ-035 Recovery on retry: q forced wrong for first check only -> exactly two s pulses, ack with err=0 in cycle 9.
REQ-036 Reset in DRIVE: reset high during cycle 2 -> s=r=0, busy=0 at next edge, no ack; a new req is then serviced normally.
REQ-037 Assertion across all tests: s & r never both high; ack never with busy low on the previous cycle.
